// File: rtl/uart_tx_arbiter_if.sv
// Bus bundle between NREQ byte requesters, the arbiter and one UART transmitter.
// Both sides use request/ready: request is held until ready is seen, then dropped; ready falls one cycle later.
interface uart_tx_arbiter_if #(
    parameter int NREQ = 4
);
    localparam int OW = $clog2(NREQ);

    logic [NREQ-1:0]   i_request;
    logic [NREQ*8-1:0] i_wdata;
    logic [NREQ-1:0]   o_ready;
    logic              o_uart_request;
    logic [31:0]       o_uart_wdata;
    logic              i_uart_ready;
    logic [OW-1:0]     o_owner;

    modport master (
        output i_request, i_wdata, i_uart_ready,
        input  o_ready, o_uart_request, o_uart_wdata, o_owner
    );

    modport slave (
        input  i_request, i_wdata, i_uart_ready,
        output o_ready, o_uart_request, o_uart_wdata, o_owner
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding bytes from NREQ requesters into one UART transmitter.
// Define UART_TX_ARBITER_LOCK_EN to hold the line for one owner until it sends 0x0A or goes idle.
module uart_tx_arbiter #(
    parameter int NREQ         = 4,
    parameter int LOCK_TIMEOUT = 50000
) (
    input  logic             i_clock,
    input  logic             i_reset,
    uart_tx_arbiter_if.slave bus,
    output logic [1:0]       dbg_state
);
    localparam int OW = $clog2(NREQ);
    localparam logic [OW:0] NREQ_W = (OW + 1)'(NREQ);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        ACK   = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [OW-1:0]   owner_q, owner_d;
    logic [OW-1:0]   rr_q, rr_d;
    logic [OW-1:0]   winner, cand;
    logic [7:0]      data_q, data_d, winner_byte;
    logic            uart_req_q, uart_req_d;
    logic [NREQ-1:0] ready_q, ready_d;
    logic [NREQ-1:0] owner_hot, elig;
    logic            found, grant, accept;

    function automatic logic [OW-1:0] wrap_add(input logic [OW-1:0] base, input logic [OW:0] off);
        logic [OW:0] sum;
        sum = {1'b0, base} + off;
        if (sum >= NREQ_W) sum = sum - NREQ_W;
        return OW'(sum);
    endfunction

    always_comb begin
        owner_hot = '0;
        owner_hot[owner_q] = 1'b1;
    end

`ifdef UART_TX_ARBITER_LOCK_EN
    localparam int CW = $clog2(LOCK_TIMEOUT + 1);
    localparam logic [CW-1:0] TMO = CW'(LOCK_TIMEOUT);

    logic          locked_q, locked_d;
    logic [CW-1:0] idle_cnt_q, idle_cnt_d, idle_inc;

    // While locked only the owner may win; the pointer already sits at owner+1 for the release.
    assign elig     = locked_q ? (bus.i_request & owner_hot) : bus.i_request;
    assign idle_inc = (idle_cnt_q == TMO) ? TMO : idle_cnt_q + 1'b1;

    always_comb begin
        locked_d   = locked_q;
        idle_cnt_d = idle_cnt_q;
        if (grant) begin
            locked_d   = 1'b1;
            idle_cnt_d = '0;
        end else if (accept && data_q == 8'h0A) begin
            locked_d = 1'b0;
        end else if (state_q == IDLE && locked_q) begin
            idle_cnt_d = idle_inc;
            if (idle_inc == TMO) locked_d = 1'b0;
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            locked_q   <= 1'b0;
            idle_cnt_q <= '0;
        end else begin
            locked_q   <= locked_d;
            idle_cnt_q <= idle_cnt_d;
        end
    end
`else
    logic unused_lock;
    assign unused_lock = grant ^ accept ^ (LOCK_TIMEOUT > 0);
    assign elig        = bus.i_request;
`endif

    always_comb begin
        found  = 1'b0;
        winner = rr_q;
        cand   = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = wrap_add(rr_q, (OW + 1)'(i));
            if (!found && elig[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    always_comb begin
        winner_byte = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (winner == OW'(k)) winner_byte = bus.i_wdata[k*8 +: 8];
        end
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rr_d       = rr_q;
        data_d     = data_q;
        uart_req_d = uart_req_q;
        ready_d    = ready_q;
        grant      = 1'b0;
        accept     = 1'b0;
        unique case (state_q)
            IDLE: begin
                uart_req_d = 1'b0;
                ready_d    = '0;
                if (found) begin
                    grant   = 1'b1;
                    owner_d = winner;
                    data_d  = winner_byte;
                    rr_d    = wrap_add(winner, (OW + 1)'(1));
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                // The owner may have dropped its request already; the byte still goes out.
                if (uart_req_q && bus.i_uart_ready) begin
                    accept     = 1'b1;
                    uart_req_d = 1'b0;
                    ready_d    = owner_hot;
                    state_d    = ACK;
                end else begin
                    uart_req_d = 1'b1;
                end
            end
            ACK: begin
                ready_d = owner_hot;
                if (!bus.i_request[owner_q] && !bus.i_uart_ready) begin
                    ready_d = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q    <= IDLE;
            owner_q    <= '0;
            rr_q       <= '0;
            data_q     <= '0;
            uart_req_q <= 1'b0;
            ready_q    <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_q       <= rr_d;
            data_q     <= data_d;
            uart_req_q <= uart_req_d;
            ready_q    <= ready_d;
        end
    end

    assign bus.o_ready        = ready_q;
    assign bus.o_uart_request = uart_req_q;
    assign bus.o_uart_wdata   = {24'h0, data_q};
    assign bus.o_owner        = owner_q;
    assign dbg_state          = state_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: vector table, corner sequences and a randomized run against a transaction model.
// Lock sequences run when UART_TX_ARBITER_LOCK_EN is defined.
module tb_uart_tx_arbiter;
    localparam int NREQ = 4;
    localparam int TMO  = 16;
    localparam int W    = 10;
`ifdef UART_TX_ARBITER_LOCK_EN
    localparam bit LOCK_BUILD = 1'b1;
`else
    localparam bit LOCK_BUILD = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] dbg_state;
    int         total = 0;
    int         bad = 0;
    int         onehot_errs = 0;
    logic [W-1:0] exp_q[$];

    typedef struct {
        logic [NREQ-1:0] mask;
        logic [31:0]     bytes;
        logic [1:0]      owner;
        int              delay;
        int              hold;
    } vec_t;
    vec_t vecs[9];

    uart_tx_arbiter_if #(.NREQ(NREQ)) bus ();

    uart_tx_arbiter #(.NREQ(NREQ), .LOCK_TIMEOUT(TMO)) dut (
        .i_clock   (clk),
        .i_reset   (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    // At most one ready bit, and only the owner's.
    always @(negedge clk) begin
        if (bus.o_ready !== '0 && bus.o_ready !== (4'b0001 << bus.o_owner)) onehot_errs++;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, got=running required=done");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] fill(input logic [7:0] b);
        return LOCK_BUILD ? 8'h0A : b;
    endfunction

    function automatic logic [31:0] mk(input logic [7:0] b0, input logic [7:0] b1,
                                       input logic [7:0] b2, input logic [7:0] b3);
        return {fill(b3), fill(b2), fill(b1), fill(b0)};
    endfunction

    task automatic chk_zero(input string tag);
        chk({tag, "_ready"}, 32'(bus.o_ready), 0);
        chk({tag, "_ureq"}, 32'(bus.o_uart_request), 0);
        chk({tag, "_wdata"}, bus.o_uart_wdata, 0);
        chk({tag, "_owner"}, 32'(bus.o_owner), 0);
        chk({tag, "_state"}, 32'(dbg_state), 0);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        bus.i_request = '0;
        bus.i_wdata = '0;
        bus.i_uart_ready = 1'b0;
        step();
        step();
        chk_zero(tag);
        rst = 1'b0;
        exp_q.delete();
    endtask

    // Transmitter side of one byte: wait for the request, stall, accept, hold, release.
    task automatic serve(input int delay, input int hold, input string tag, output int lat);
        logic [W-1:0] got, want;
        logic stable;
        lat = 0;
        while (bus.o_uart_request !== 1'b1 && lat < 20) begin
            step();
            lat++;
        end
        chk({tag, "_ureq_seen"}, 32'(bus.o_uart_request), 1);
        got = {bus.o_owner, bus.o_uart_wdata[7:0]};
        chk({tag, "_sb_pending"}, 32'(exp_q.size() > 0), 1);
        want = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
        chk({tag, "_owner_data"}, 32'(got), 32'(want));
        chk({tag, "_wdata_hi"}, 32'(bus.o_uart_wdata[31:8]), 0);
        chk({tag, "_ready_pre"}, 32'(bus.o_ready), 0);
        if (delay > 0) begin
            stable = 1'b1;
            repeat (delay) begin
                step();
                if (bus.o_uart_request !== 1'b1 || bus.o_uart_wdata !== {24'h0, want[7:0]} ||
                    bus.o_ready !== '0) stable = 1'b0;
            end
            chk({tag, "_stall_stable"}, 32'(stable), 1);
        end
        bus.i_uart_ready = 1'b1;
        step();
        chk({tag, "_ready_on"}, 32'(bus.o_ready), 32'(1 << want[W-1:8]));
        chk({tag, "_ureq_off"}, 32'(bus.o_uart_request), 0);
        bus.i_uart_ready = 1'b0;
        repeat (hold) begin
            step();
            chk({tag, "_ready_hold"}, 32'(bus.o_ready), 32'(1 << want[W-1:8]));
        end
        bus.i_request = '0;
        step();
        chk({tag, "_ready_off"}, 32'(bus.o_ready), 0);
    endtask

    task automatic do_txn(input logic [NREQ-1:0] mask, input logic [31:0] bytes, input logic [1:0] exp_owner,
                          input int delay, input int hold, input string tag);
        int lat;
        int o;
        o = int'(exp_owner);
        exp_q.push_back({exp_owner, bytes[8*o +: 8]});
        bus.i_request = mask;
        bus.i_wdata = bytes;
        step();
        serve(delay, hold, tag, lat);
        chk({tag, "_latency"}, 32'(lat + 1), 2);
    endtask

    initial begin
        int lat, n, grants, win, k, m_rr, m_owner;
        logic prev, m_locked, quiet;
        logic [NREQ-1:0] mask;
        logic [31:0] bytes;

        // Expected winners follow round-robin from pointer 0 after reset.
        vecs[0] = '{4'b0100, mk(8'h10, 8'h11, 8'h12, 8'h13), 2'd2, 0, 1};
        vecs[1] = '{4'b0101, mk(8'h20, 8'h21, 8'h22, 8'h23), 2'd0, 1, 0};
        vecs[2] = '{4'b0101, mk(8'h30, 8'h31, 8'h32, 8'h33), 2'd2, 2, 2};
        vecs[3] = '{4'b1111, mk(8'h40, 8'h41, 8'h42, 8'h43), 2'd3, 0, 0};
        vecs[4] = '{4'b0010, mk(8'h50, 8'h51, 8'h52, 8'h53), 2'd1, 3, 1};
        vecs[5] = '{4'b1001, mk(8'h60, 8'h61, 8'h62, 8'h63), 2'd3, 1, 0};
        vecs[6] = '{4'b0011, mk(8'h70, 8'h71, 8'h72, 8'h73), 2'd0, 0, 2};
        vecs[7] = '{4'b0011, mk(8'h80, 8'h81, 8'h82, 8'h83), 2'd1, 2, 0};
        vecs[8] = '{4'b1011, mk(8'hFF, 8'h00, 8'h55, 8'hAA), 2'd3, 0, 1};

        bus.i_request = '0;
        bus.i_wdata = '0;
        bus.i_uart_ready = 1'b0;
        #1;
        chk_zero("por");

        // Single requester 2 sends 0x41.
        do_reset("rst_a");
        do_txn(4'b0100, {8'h33, 8'h41, 8'h22, 8'h11}, 2'd2, 0, 2, "single");

        // Transmitter stalls for 1000 cycles.
        do_reset("rst_b");
        do_txn(4'b0010, {8'h00, 8'h00, 8'h5A, 8'h00}, 2'd1, 1000, 1, "stall");

        // Owner drops mid-transfer; requester 3 knocks during ISSUE/ACK and leaves.
        do_reset("rst_c");
        exp_q.push_back({2'd0, 8'h5C});
        bus.i_wdata = 32'h0000_005C;
        bus.i_request = 4'b0001;
        step();
        bus.i_request = 4'b1000;
        serve(2, 0, "drop", lat);
        repeat (3) step();
        chk("noqueue_state", 32'(dbg_state), 0);
        chk("noqueue_ureq", 32'(bus.o_uart_request), 0);
        chk("noqueue_owner", 32'(bus.o_owner), 0);

        // Reset pulsed while a byte is being issued.
        do_reset("rst_d");
        do_txn(4'b0001, 32'h0000_000A, 2'd0, 0, 0, "pre_rst");
        do_txn(4'b0100, 32'h000A_0000, 2'd2, 0, 0, "pre_rst2");
        bus.i_request = 4'b0100;
        bus.i_wdata = 32'h0077_0000;
        step();
        step();
        chk("mid_issue_ureq", 32'(bus.o_uart_request), 1);
        rst = 1'b1;
        bus.i_uart_ready = 1'b1;
        bus.i_request = 4'b0101;
        #2;
        chk_zero("async_rst");
        step();
        step();
        chk_zero("held_rst");
        rst = 1'b0;
        bus.i_uart_ready = 1'b0;
        bus.i_request = '0;
        quiet = 1'b1;
        repeat (5) begin
            step();
            if (bus.o_ready !== '0 || bus.o_uart_request !== 1'b0) quiet = 1'b0;
        end
        chk("post_rst_quiet", 32'(quiet), 1);
        do_txn(4'b1100, {8'h0A, 8'h0A, 8'h00, 8'h00}, 2'd2, 0, 0, "post_rst");

        // Vector table.
        do_reset("rst_e");
        for (int i = 0; i < 9; i++) begin
            do_txn(vecs[i].mask, vecs[i].bytes, vecs[i].owner, vecs[i].delay, vecs[i].hold,
                   $sformatf("vec%0d", i));
        end

        // Requesters 0 and 1 request continuously and re-request right after each ACK.
        do_reset("rst_f");
        bus.i_wdata = {16'h0, fill(8'h31), fill(8'h30)};
        bus.i_request = 4'b0011;
        grants = 0;
        prev = 1'b0;
        for (int c = 0; c < 200 && grants < 8; c++) begin
            step();
            if (bus.o_uart_request === 1'b1 && !prev) begin
                chk($sformatf("cont_owner%0d", grants), 32'(bus.o_owner), 32'(grants % 2));
                chk($sformatf("cont_data%0d", grants), bus.o_uart_wdata,
                    {24'h0, fill(8'h30 + 8'(grants % 2))});
                grants++;
            end
            prev = bus.o_uart_request;
            bus.i_uart_ready = bus.o_uart_request;
            for (int j = 0; j < 2; j++) bus.i_request[j] = !bus.o_ready[j];
        end
        chk("cont_grants", 32'(grants), 8);
        bus.i_request = '0;
        bus.i_uart_ready = 1'b0;
        repeat (3) step();

        if (LOCK_BUILD) begin
            // Requester 1 sends "AB\n" while requester 3 waits.
            do_reset("rst_g");
            do_txn(4'b1010, {8'h5A, 8'h00, 8'h41, 8'h00}, 2'd1, 0, 0, "lock_a");
            do_txn(4'b1010, {8'h5A, 8'h00, 8'h42, 8'h00}, 2'd1, 1, 0, "lock_b");
            do_txn(4'b1010, {8'h5A, 8'h00, 8'h0A, 8'h00}, 2'd1, 0, 1, "lock_nl");
            do_txn(4'b1010, {8'h5A, 8'h00, 8'h43, 8'h00}, 2'd3, 0, 0, "lock_next");

            // Requester 0 goes silent after 'X'; requester 2 waits out the timeout.
            do_reset("rst_h");
            do_txn(4'b0001, 32'h0000_0058, 2'd0, 0, 0, "tmo_x");
            exp_q.push_back({2'd2, 8'h52});
            bus.i_request = 4'b0100;
            bus.i_wdata = 32'h0052_0000;
            n = 0;
            while (bus.o_owner !== 2'd2 && n < 100) begin
                step();
                n++;
            end
            chk("tmo_wait_min", 32'(n >= TMO), 1);
            chk("tmo_wait_max", 32'(n <= TMO + 4), 1);
            serve(0, 0, "tmo_serve", lat);
        end

        // Randomized run against a transaction-level model.
        do_reset("rst_r");
        m_rr = 0;
        m_owner = 0;
        m_locked = 1'b0;
        for (int r = 0; r < 40; r++) begin
            mask = NREQ'($urandom_range(1, 15));
            if (LOCK_BUILD && m_locked) mask[m_owner] = 1'b1;
            for (int j = 0; j < NREQ; j++) begin
                bytes[8*j +: 8] = 8'($urandom_range(0, 255));
                if (LOCK_BUILD && $urandom_range(0, 3) == 0) bytes[8*j +: 8] = 8'h0A;
            end
            win = -1;
            for (int i = 0; i < NREQ; i++) begin
                k = (m_rr + i) % NREQ;
                if (win < 0 && mask[k] && (!(LOCK_BUILD && m_locked) || k == m_owner)) win = k;
            end
            m_rr = (win + 1) % NREQ;
            m_owner = win;
            if (LOCK_BUILD) m_locked = (bytes[8*win +: 8] != 8'h0A);
            do_txn(mask, bytes, 2'(win), $urandom_range(0, 3), $urandom_range(0, 2), $sformatf("rand%0d", r));
        end

        chk("ready_onehot", 32'(onehot_errs), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
